// File: rtl/cache_op_sequencer_if.sv
// Handshake bundle between the MEM stage, the cache-op sequencer and the icache/dcache maintenance ports.
// The sequencer connects through the slave modport; the environment (MEM stage plus caches) uses master.
interface cache_op_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int OP_W   = 5
);
    logic              op_valid_i;
    logic [OP_W-1:0]   op_code_i;
    logic [ADDR_W-1:0] op_addr_i;
    logic              op_exc_i;
    logic              flush_i;
    logic              icache_req_o;
    logic [OP_W-1:0]   icache_op_o;
    logic [ADDR_W-1:0] icache_addr_o;
    logic              icache_ok_i;
    logic              dcache_req_o;
    logic [OP_W-1:0]   dcache_op_o;
    logic [ADDR_W-1:0] dcache_addr_o;
    logic              dcache_ok_i;
    logic              op_done_o;
    logic              busy_o;
    logic              op_timeout_o;

    modport master (
        output op_valid_i, op_code_i, op_addr_i, op_exc_i, flush_i, icache_ok_i, dcache_ok_i,
        input  icache_req_o, icache_op_o, icache_addr_o, dcache_req_o, dcache_op_o, dcache_addr_o,
        input  op_done_o, busy_o, op_timeout_o
    );

    modport slave (
        input  op_valid_i, op_code_i, op_addr_i, op_exc_i, flush_i, icache_ok_i, dcache_ok_i,
        output icache_req_o, icache_op_o, icache_addr_o, dcache_req_o, dcache_op_o, dcache_addr_o,
        output op_done_o, busy_o, op_timeout_o
    );
endinterface

// File: rtl/cache_op_sequencer.sv
// Sequences one MEM-stage CACHE instruction onto the icache/dcache maintenance port and pulses op_done.
// Define CACHE_OP_TIMEOUT_EN to build the request watchdog (TIMEOUT_CYC, CNT_W); otherwise REQ waits forever.
module cache_op_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int OP_W        = 5,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input logic                 clk,
    input logic                 rst,
    cache_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e            state_r;
    state_e            state_nxt_s;
    logic              drop_r;
    logic              drop_nxt_s;
    logic              accept_s;
    logic              sel_ok_s;
    logic              timeout_hit_s;
    logic [OP_W-1:0]   op_r;
    logic [ADDR_W-1:0] addr_r;

    // A watchdog counter too narrow to reach its limit would never fire.
    if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cnt_w_check
        $error("cache_op_sequencer: CNT_W too narrow for TIMEOUT_CYC");
    end

    // Completion strobe from whichever cache the latched op targets; the other cache's ok is ignored.
    always_comb begin
        if (op_r[0]) begin
            sel_ok_s = bus.dcache_ok_i;
        end else begin
            sel_ok_s = bus.icache_ok_i;
        end
    end

    // Next-state and drop-flag logic; a flushed request is still held until its ok, then retired silently.
    always_comb begin
        state_nxt_s = state_r;
        drop_nxt_s  = drop_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                drop_nxt_s = 1'b0;
                if (bus.op_valid_i && !bus.flush_i) begin
                    accept_s = 1'b1;
                    if (!bus.op_exc_i && !bus.op_code_i[1]) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (sel_ok_s || timeout_hit_s) begin
                    state_nxt_s = drop_r ? ST_IDLE : ST_DONE;
                    drop_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_REQ;
                    drop_nxt_s  = drop_r | bus.flush_i;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                drop_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                drop_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, drop flag and the op/address latch captured on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
            op_r    <= {OP_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            drop_r  <= drop_nxt_s;
            if (accept_s) begin
                op_r   <= bus.op_code_i;
                addr_r <= bus.op_addr_i;
            end
        end
    end

`ifdef CACHE_OP_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;

    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts REQ cycles without ok; the timeout flag lines up with the DONE cycle it causes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if ((state_r == ST_REQ) && !sel_ok_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
            timeout_r <= (state_r == ST_REQ) && !sel_ok_s && timeout_hit_s && !drop_r;
        end
    end

    assign bus.op_timeout_o = timeout_r;
`else
    assign timeout_hit_s    = 1'b0;
    assign bus.op_timeout_o = 1'b0;
`endif

    assign bus.icache_req_o  = (state_r == ST_REQ) && !op_r[0];
    assign bus.dcache_req_o  = (state_r == ST_REQ) && op_r[0];
    assign bus.icache_op_o   = op_r;
    assign bus.dcache_op_o   = op_r;
    assign bus.icache_addr_o = addr_r;
    assign bus.dcache_addr_o = addr_r;
    assign bus.op_done_o     = (state_r == ST_DONE);
    assign bus.busy_o        = (state_r != ST_IDLE);

endmodule
